// File: rtl/instruction_dispatcher.sv
// Instruction dispatcher: read side of the instruction FIFO. Pops instructions, decodes them
// and issues opcode/operand to the NLP datapath over a valid/ready handshake.
// Latency: start to first issue_valid is 3 cycles; one instruction per 3 cycles with ready high.
// Backpressure: issue_valid and fields hold until issue_ready; no further pops during the stall.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   start, flush        start fetching from IDLE / synchronous abort back to IDLE
//   fifo_empty          FIFO empty flag
//   fifo_data           FIFO registered read data, valid the cycle after a pop
//   fifo_rd_en          FIFO pop request (combinational)
//   issue_valid/ready   issue handshake toward the datapath
//   issue_opcode        opcode of the presented instruction (0 when not valid)
//   issue_operand       operand of the presented instruction (0 when not valid)
//   busy                FSM not in IDLE
//   halted              HALT retired; sticky until start or reset
//   illegal_err         illegal opcode seen; sticky until reset
//   perf_issue_cnt      (DISPATCH_PERF_CNT_EN only) saturating issue handshake count
//   perf_stall_cnt      (DISPATCH_PERF_CNT_EN only) saturating stall cycle count
//
// Optional feature macro: DISPATCH_PERF_CNT_EN adds the two perf counters and CNT_W.

module instruction_dispatcher #(
  parameter int INSTR_W = 13,
  parameter int OP_W    = 4
`ifdef DISPATCH_PERF_CNT_EN
  ,
  parameter int CNT_W   = 16
`endif
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      flush,
  input  logic                      fifo_empty,
  input  logic [INSTR_W-1:0]        fifo_data,
  output logic                      fifo_rd_en,
  output logic                      issue_valid,
  input  logic                      issue_ready,
  output logic [OP_W-1:0]           issue_opcode,
  output logic [INSTR_W-OP_W-1:0]   issue_operand,
  output logic                      busy,
  output logic                      halted,
  output logic                      illegal_err
`ifdef DISPATCH_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]          perf_issue_cnt,
  output logic [CNT_W-1:0]          perf_stall_cnt
`endif
);

  localparam int OPND_W = INSTR_W - OP_W;

  // Opcode map: 0 is NOP, all-ones is HALT, all-ones-minus-one is the reserved illegal code.
  localparam logic [OP_W-1:0] OP_NOP  = '0;
  localparam logic [OP_W-1:0] OP_HALT = '1;
  localparam logic [OP_W-1:0] OP_ILL  = {{(OP_W-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_LOAD  = 2'd2,
    S_ISSUE = 2'd3
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [INSTR_W-1:0]  instr;
  logic [INSTR_W-1:0]  instr_nxt;
  logic                halted_nxt;
  logic                illegal_nxt;
  logic [OP_W-1:0]     load_op;

  // The FIFO output is registered, so in LOAD fifo_data already holds the popped word.
  // Decoding it directly (rather than from the latched copy) is what keeps the
  // FETCH -> LOAD -> ISSUE cadence at three cycles.
  assign load_op = fifo_data[INSTR_W-1 -: OP_W];

  // State and sticky flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      instr       <= '0;
      halted      <= 1'b0;
      illegal_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      instr       <= instr_nxt;
      halted      <= halted_nxt;
      illegal_err <= illegal_nxt;
    end
  end

  // Next-state, decode and pop request
  always_comb begin
    state_nxt   = state;
    instr_nxt   = instr;
    halted_nxt  = halted;
    illegal_nxt = illegal_err;
    fifo_rd_en  = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt  = S_FETCH;
          halted_nxt = 1'b0;
        end
      end

      S_FETCH: begin
        // Only one pop can be outstanding: we leave FETCH in the same cycle we pop.
        if (!fifo_empty) begin
          fifo_rd_en = 1'b1;
          state_nxt  = S_LOAD;
        end
      end

      S_LOAD: begin
        instr_nxt = fifo_data;
        if (load_op == OP_NOP) begin
          state_nxt = S_FETCH;
        end else if (load_op == OP_ILL) begin
          illegal_nxt = 1'b1;
          state_nxt   = S_FETCH;
        end else if (load_op == OP_HALT) begin
          halted_nxt = 1'b1;
          state_nxt  = S_IDLE;
        end else begin
          state_nxt = S_ISSUE;
        end
      end

      S_ISSUE: begin
        if (issue_ready) begin
          state_nxt = S_FETCH;
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    // Flush overrides every transition above. Sticky flags keep their current value
    // (this also means a start in the same cycle does not clear halted), and the
    // held instruction, including one just arriving in LOAD, is dropped.
    if (flush) begin
      state_nxt   = S_IDLE;
      instr_nxt   = '0;
      halted_nxt  = halted;
      illegal_nxt = illegal_err;
    end
  end

  // Outputs decode straight from the state register so an async reset clears them at once.
  assign issue_valid   = (state == S_ISSUE);
  assign busy          = (state != S_IDLE);
  assign issue_opcode  = issue_valid ? instr[INSTR_W-1 -: OP_W] : '0;
  assign issue_operand = issue_valid ? instr[OPND_W-1:0]        : '0;

`ifdef DISPATCH_PERF_CNT_EN
  logic issue_fire;
  logic stall_cyc;

  // A handshake coinciding with flush is not an accepted issue.
  assign issue_fire = issue_valid & issue_ready & ~flush;
  assign stall_cyc  = ((state == S_ISSUE) && !issue_ready) ||
                      ((state == S_FETCH) && fifo_empty);

  // Saturating counters, cleared by reset only
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_issue_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (issue_fire && (perf_issue_cnt != '1)) begin
        perf_issue_cnt <= perf_issue_cnt + CNT_W'(1);
      end
      if (stall_cyc && (perf_stall_cnt != '1)) begin
        perf_stall_cnt <= perf_stall_cnt + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_instruction_dispatcher.sv
// Self-checking bench for instruction_dispatcher: FIFO model, handshake logger and a
// program-level reference model (expected issue list and sticky flags per program).
// Scenarios: reset, basic decode, latency/throughput, backpressure, empty/illegal, flush, random.

module tb_instruction_dispatcher;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic        fifo_empty;
  logic [12:0] fifo_data = '0;
  logic        fifo_rd_en;
  logic        issue_valid;
  logic        issue_ready = 1'b0;
  logic [3:0]  issue_opcode;
  logic [8:0]  issue_operand;
  logic        busy;
  logic        halted;
  logic        illegal_err;
`ifdef DISPATCH_PERF_CNT_EN
  logic [15:0] perf_issue_cnt;
  logic [15:0] perf_stall_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  instruction_dispatcher dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .flush         (flush),
    .fifo_empty    (fifo_empty),
    .fifo_data     (fifo_data),
    .fifo_rd_en    (fifo_rd_en),
    .issue_valid   (issue_valid),
    .issue_ready   (issue_ready),
    .issue_opcode  (issue_opcode),
    .issue_operand (issue_operand),
    .busy          (busy),
    .halted        (halted),
    .illegal_err   (illegal_err)
`ifdef DISPATCH_PERF_CNT_EN
    ,
    .perf_issue_cnt(perf_issue_cnt),
    .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  // FIFO model with registered read data
  logic [12:0] fmem [0:255];
  logic [7:0]  wr_ptr = '0;
  logic [7:0]  rd_ptr = '0;
  logic        fifo_clr = 1'b0;

  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (fifo_clr) begin
      rd_ptr <= wr_ptr;
    end else if (fifo_rd_en && !fifo_empty) begin
      fifo_data <= fmem[rd_ptr];
      rd_ptr    <= rd_ptr + 8'd1;
    end
  end

  // Handshake logger and protocol watcher
  int          cyc = 0;
  logic [12:0] iss_log [0:1023];
  int          iss_cyc [0:1023];
  int          iss_n = 0;
  int          pop_n = 0;
  int          bad_rd = 0;
  int          bad_stab = 0;
  logic        pv = 1'b0;
  logic        phs = 1'b0;
  logic        pfl = 1'b0;
  logic [12:0] pfield = '0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_rd_en && fifo_empty) bad_rd <= bad_rd + 1;
    if (fifo_rd_en) pop_n <= pop_n + 1;
    if (rst_n && issue_valid && issue_ready && !flush) begin
      iss_log[iss_n] <= {issue_opcode, issue_operand};
      iss_cyc[iss_n] <= cyc;
      iss_n          <= iss_n + 1;
    end
    if (rst_n && pv && !phs && !pfl) begin
      if (!issue_valid || ({issue_opcode, issue_operand} != pfield)) bad_stab <= bad_stab + 1;
    end
    pv     <= rst_n && issue_valid;
    phs    <= issue_ready;
    pfl    <= flush;
    pfield <= {issue_opcode, issue_operand};
  end

  // Program-level reference model
  logic [12:0] prog_q [$];
  logic [12:0] exp_q [$];
  logic        exp_ill;
  logic        exp_hlt;

  task automatic run_model();
    bit stop = 0;
    int op;
    exp_q.delete();
    exp_ill = 1'b0;
    exp_hlt = 1'b0;
    foreach (prog_q[i]) begin
      if (!stop) begin
        op = int'(prog_q[i]) / 512;
        if (op == 15) begin
          exp_hlt = 1'b1;
          stop = 1;
        end else if (op == 14) begin
          exp_ill = 1'b1;
        end else if (op != 0) begin
          exp_q.push_back(prog_q[i]);
        end
      end
    end
  endtask

  // Stimulus helpers (called at posedge + 1)
  task automatic push(input logic [12:0] v);
    fmem[wr_ptr] = v;
    wr_ptr = wr_ptr + 8'd1;
  endtask

  task automatic push_prog();
    foreach (prog_q[i]) push(prog_q[i]);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    flush = 1'b0;
    issue_ready = 1'b0;
    fifo_clr = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    fifo_clr = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    int n = 0;
    while (!issue_valid && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    ok = issue_valid;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    int n = 0;
    while (busy && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    ok = !busy;
  endtask

  task automatic test_reset();
    bit ok;
    do_reset();
    n_checks++;
    if ({issue_valid, fifo_rd_en, busy, halted, illegal_err} !== 5'b0) begin
      n_errors++;
      $display("FAIL reset_ctrl got %b want 00000", {issue_valid, fifo_rd_en, busy, halted, illegal_err});
    end
    n_checks++;
    if ({issue_opcode, issue_operand} !== 13'h0) begin
      n_errors++;
      $display("FAIL reset_fields got %h want 0000", {issue_opcode, issue_operand});
    end
    push(13'h03FF);
    pulse_start();
    wait_valid(20, ok);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL reset_reach_issue got valid=0 want valid=1");
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({issue_valid, fifo_rd_en, busy, halted, illegal_err} !== 5'b0) begin
      n_errors++;
      $display("FAIL reset_async got %b want 00000", {issue_valid, fifo_rd_en, busy, halted, illegal_err});
    end
    n_checks++;
    if ({issue_opcode, issue_operand} !== 13'h0) begin
      n_errors++;
      $display("FAIL reset_async_fields got %h want 0000", {issue_opcode, issue_operand});
    end
    do_reset();
  endtask

  task automatic test_basic();
    bit ok;
    int base;
    do_reset();
    prog_q = '{13'h00A5, 13'h03FF, 13'h1E00};
    run_model();
    push_prog();
    issue_ready = 1'b1;
    base = iss_n;
    pulse_start();
    wait_idle(50, ok);
    @(negedge clk);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL basic_timeout got busy=1 want busy=0");
    end
    n_checks++;
    if ((iss_n - base) != exp_q.size()) begin
      n_errors++;
      $display("FAIL basic_count got %0d want %0d", iss_n - base, exp_q.size());
    end
    n_checks++;
    if (iss_log[base] !== 13'h03FF) begin
      n_errors++;
      $display("FAIL basic_issue got %h want 03ff (op 1 operand 1ff)", iss_log[base]);
    end
    n_checks++;
    if ({halted, busy, illegal_err} !== {exp_hlt, 1'b0, exp_ill}) begin
      n_errors++;
      $display("FAIL basic_flags got %b want %b", {halted, busy, illegal_err}, {exp_hlt, 1'b0, exp_ill});
    end
    issue_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    bit ok;
    int base;
    int lat;
    do_reset();
    prog_q = '{13'h0345, 13'h1A01, 13'h0C12, 13'h1FFF};
    run_model();
    push_prog();
    issue_ready = 1'b1;
    base = iss_n;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = 1;
    while (!issue_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    n_checks++;
    if (lat != 3) begin
      n_errors++;
      $display("FAIL latency got %0d want 3", lat);
    end
    wait_idle(50, ok);
    @(negedge clk);
    n_checks++;
    if (!ok || (iss_n - base) != 3) begin
      n_errors++;
      $display("FAIL b2b_count got %0d want 3", iss_n - base);
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (iss_log[base + i] !== exp_q[i]) begin
          n_errors++;
          $display("FAIL b2b_data[%0d] got %h want %h", i, iss_log[base + i], exp_q[i]);
        end
      end
      for (int i = 0; i < 2; i++) begin
        n_checks++;
        if ((iss_cyc[base + i + 1] - iss_cyc[base + i]) != 3) begin
          n_errors++;
          $display("FAIL throughput[%0d] got %0d want 3", i, iss_cyc[base + i + 1] - iss_cyc[base + i]);
        end
      end
    end
    issue_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    bit ok;
    int base;
    int pops;
    do_reset();
    prog_q = '{13'h0C12, 13'h03FF};
    run_model();
    push_prog();
    base = iss_n;
    pulse_start();
    wait_valid(20, ok);
    pops = pop_n;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if ({issue_valid, issue_opcode, issue_operand} !== {1'b1, exp_q[0]}) begin
        n_errors++;
        $display("FAIL bp_hold[%0d] got %b_%h want 1_%h", i, issue_valid, {issue_opcode, issue_operand}, exp_q[0]);
      end
    end
    n_checks++;
    if (pop_n != pops) begin
      n_errors++;
      $display("FAIL bp_no_pop got %0d pops want %0d", pop_n, pops);
    end
    @(posedge clk);
    #1;
    issue_ready = 1'b1;
    @(posedge clk);
    #1;
    issue_ready = 1'b0;
    n_checks++;
    if ((iss_n - base) != 1) begin
      n_errors++;
      $display("FAIL bp_one_hs got %0d want 1", iss_n - base);
    end
    wait_valid(20, ok);
    @(negedge clk);
    n_checks++;
    if ({issue_valid, issue_opcode, issue_operand} !== {1'b1, exp_q[1]}) begin
      n_errors++;
      $display("FAIL bp_next got %b_%h want 1_%h", issue_valid, {issue_opcode, issue_operand}, exp_q[1]);
    end
  endtask

  task automatic test_empty_illegal();
    bit ok;
    int base;
    do_reset();
    issue_ready = 1'b1;
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if ({fifo_rd_en, busy} !== 2'b01) begin
        n_errors++;
        $display("FAIL empty_fetch[%0d] got rd_en/busy %b want 01", i, {fifo_rd_en, busy});
      end
    end
    @(posedge clk);
    #1;
    prog_q = '{13'h1C00, 13'h03FF, 13'h1E00};
    run_model();
    base = iss_n;
    push_prog();
    wait_idle(50, ok);
    @(negedge clk);
    n_checks++;
    if (illegal_err !== exp_ill) begin
      n_errors++;
      $display("FAIL illegal_flag got %b want %b", illegal_err, exp_ill);
    end
    n_checks++;
    if (!ok || (iss_n - base) != 1 || iss_log[base] !== exp_q[0]) begin
      n_errors++;
      $display("FAIL illegal_skip got count %0d first %h want 1 %h", iss_n - base, iss_log[base], exp_q[0]);
    end
    issue_ready = 1'b0;
  endtask

  task automatic test_flush();
    bit ok;
    int base;
    do_reset();
    push(13'h1E00);
    push(13'h0A11);
    push(13'h1733);
    pulse_start();
    wait_idle(20, ok);
    // start and flush together: flush wins, halted is not cleared
    start = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({busy, halted} !== 2'b01) begin
      n_errors++;
      $display("FAIL flush_start got busy/halted %b want 01", {busy, halted});
    end
    base = iss_n;
    pulse_start();
    n_checks++;
    if (halted !== 1'b0) begin
      n_errors++;
      $display("FAIL start_clears_halt got %b want 0", halted);
    end
    @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({busy, issue_valid} !== 2'b00 || iss_n != base) begin
      n_errors++;
      $display("FAIL flush_load got busy/valid %b issues %0d want 00 0", {busy, issue_valid}, iss_n - base);
    end
    @(posedge clk);
    #1;
    pulse_start();
    wait_valid(20, ok);
    n_checks++;
    if (!ok || {issue_opcode, issue_operand} !== 13'h1733) begin
      n_errors++;
      $display("FAIL flush_refetch got %h want 1733", {issue_opcode, issue_operand});
    end
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({busy, issue_valid} !== 2'b00 || iss_n != base) begin
      n_errors++;
      $display("FAIL flush_issue got busy/valid %b issues %0d want 00 0", {busy, issue_valid}, iss_n - base);
    end
  endtask

  task automatic test_random();
    bit ok;
    int base;
    int op;
    for (int r = 0; r < 3; r++) begin
      do_reset();
      prog_q.delete();
      for (int i = 0; i < 24; i++) begin
        op = ($urandom_range(0, 29) == 0) ? 15 : int'($urandom_range(0, 14));
        prog_q.push_back(13'(op * 512 + int'($urandom_range(0, 511))));
      end
      prog_q.push_back(13'h1E00);
      run_model();
      push_prog();
      base = iss_n;
      pulse_start();
      wait_idle(0, ok);
      begin
        int n = 0;
        while (busy && n < 3000) begin
          issue_ready = 1'($urandom_range(0, 1));
          @(posedge clk);
          #1;
          n++;
        end
      end
      issue_ready = 1'b0;
      @(negedge clk);
      n_checks++;
      if (busy || (iss_n - base) != exp_q.size()) begin
        n_errors++;
        $display("FAIL rand%0d_count got busy %b count %0d want 0 %0d", r, busy, iss_n - base, exp_q.size());
      end else begin
        foreach (exp_q[i]) begin
          n_checks++;
          if (iss_log[base + i] !== exp_q[i]) begin
            n_errors++;
            $display("FAIL rand%0d_data[%0d] got %h want %h", r, i, iss_log[base + i], exp_q[i]);
          end
        end
      end
      n_checks++;
      if ({halted, illegal_err} !== {exp_hlt, exp_ill}) begin
        n_errors++;
        $display("FAIL rand%0d_flags got %b want %b", r, {halted, illegal_err}, {exp_hlt, exp_ill});
      end
    end
  endtask

`ifdef DISPATCH_PERF_CNT_EN
  task automatic test_perf();
    bit ok;
    do_reset();
    prog_q = '{13'h0211, 13'h0422, 13'h0633, 13'h1E00};
    push_prog();
    pulse_start();
    wait_valid(20, ok);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    issue_ready = 1'b1;
    wait_idle(50, ok);
    issue_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if (perf_issue_cnt !== 16'd3 || perf_stall_cnt !== 16'd2) begin
      n_errors++;
      $display("FAIL perf_cnt got %0d/%0d want 3/2", perf_issue_cnt, perf_stall_cnt);
    end
  endtask
`endif

  task automatic test_protocol();
    n_checks++;
    if (bad_rd != 0) begin
      n_errors++;
      $display("FAIL pop_while_empty got %0d want 0", bad_rd);
    end
    n_checks++;
    if (bad_stab != 0) begin
      n_errors++;
      $display("FAIL issue_stability got %0d violations want 0", bad_stab);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_empty_illegal();
    test_flush();
    test_random();
`ifdef DISPATCH_PERF_CNT_EN
    test_perf();
`endif
    test_protocol();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
